// File: rtl/if_fetch_stage_if.sv
// Fetch-stage bus: hazard/redirect inputs, instruction-memory handshake and IF/ID outputs.
// With IF_PERF_CNT_EN defined the bus also carries the fetch_cnt/stall_cnt counters.
interface if_fetch_stage_if;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic [31:0] pc_out;
    logic [31:0] ins_out;
    logic        en_reg;
`ifdef IF_PERF_CNT_EN
    logic [31:0] fetch_cnt;
    logic [31:0] stall_cnt;
`endif

    // imem handshake: imem_req is a level; the word on imem_rdata is taken in any cycle
    // where imem_req & imem_ready, and belongs only to the imem_addr shown that cycle.
    modport master (
        input  stall, redirect, redirect_pc, imem_ready, imem_rdata,
        output imem_req, imem_addr, pc_out, ins_out, en_reg
`ifdef IF_PERF_CNT_EN
        , output fetch_cnt, stall_cnt
`endif
    );

    modport slave (
        output stall, redirect, redirect_pc, imem_ready, imem_rdata,
        input  imem_req, imem_addr, pc_out, ins_out, en_reg
`ifdef IF_PERF_CNT_EN
        , input fetch_cnt, stall_cnt
`endif
    );
endinterface

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: owns the PC, fetches from imem and writes {PC+4, instr} into IF/ID.
// Optional IF_PERF_CNT_EN adds fetch/stall performance counters on the bus.
module if_fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
    input  logic       clk,
    input  logic       rst,
    if_fetch_stage_if.master bus,
    output logic [1:0] dbg_state_o
);

    typedef enum logic [1:0] {
        S_BOOT = 2'd0,
        S_REQ  = 2'd1,
        S_HOLD = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] pc_out_q, pc_out_d;
    logic [31:0] ins_q, ins_d;
    logic        en_q, en_d;
    logic [31:0] hold_q, hold_d;
    logic        bubble_d;
    logic [31:0] target;
    logic [31:0] pc_plus4;
    logic        unused_rpc_lo;

    assign target        = {bus.redirect_pc[31:2], 2'b00};
    assign pc_plus4      = pc_q + 32'd4;
    assign unused_rpc_lo = ^bus.redirect_pc[1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_BOOT;
            pc_q     <= RESET_PC;
            pc_out_q <= 32'h0;
            ins_q    <= 32'h0;
            en_q     <= 1'b0;
            hold_q   <= 32'h0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            pc_out_q <= pc_out_d;
            ins_q    <= ins_d;
            en_q     <= en_d;
            hold_q   <= hold_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        pc_out_d = pc_out_q;
        ins_d    = ins_q;
        en_d     = 1'b0;
        hold_d   = hold_q;
        bubble_d = 1'b0;
        // Redirect beats stall and any returning word; BOOT only retargets the PC.
        if (state_q != S_BOOT && bus.redirect) begin
            pc_d     = target;
            hold_d   = 32'h0;
            ins_d    = NOP_WORD;
            pc_out_d = 32'h0;
            en_d     = 1'b1;
            bubble_d = 1'b1;
            state_d  = S_REQ;
        end else begin
            case (state_q)
                S_BOOT: begin
                    state_d = S_REQ;
                    if (bus.redirect) pc_d = target;
                end
                S_REQ: begin
                    if (bus.imem_ready) begin
                        if (bus.stall) begin
                            hold_d  = bus.imem_rdata;
                            state_d = S_HOLD;
                        end else begin
                            pc_out_d = pc_plus4;
                            ins_d    = bus.imem_rdata;
                            en_d     = 1'b1;
                            pc_d     = pc_plus4;
                        end
                    end
                end
                S_HOLD: begin
                    if (!bus.stall) begin
                        pc_out_d = pc_plus4;
                        ins_d    = hold_q;
                        en_d     = 1'b1;
                        pc_d     = pc_plus4;
                        state_d  = S_REQ;
                    end
                end
                default: state_d = S_BOOT;
            endcase
        end
    end

    assign bus.imem_req  = (state_q == S_REQ);
    assign bus.imem_addr = pc_q;
    assign bus.pc_out    = pc_out_q;
    assign bus.ins_out   = ins_q;
    assign bus.en_reg    = en_q;
    assign dbg_state_o   = state_q;

`ifdef IF_PERF_CNT_EN
    logic [31:0] fetch_cnt_q, stall_cnt_q;
    logic        stall_cycle;

    assign stall_cycle = (state_q == S_HOLD) || (state_q == S_REQ && !bus.imem_ready);

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_cnt_q <= 32'h0;
            stall_cnt_q <= 32'h0;
        end else begin
            if (en_d && !bubble_d) fetch_cnt_q <= fetch_cnt_q + 32'd1;
            if (stall_cycle)       stall_cnt_q <= stall_cnt_q + 32'd1;
        end
    end

    assign bus.fetch_cnt = fetch_cnt_q;
    assign bus.stall_cnt = stall_cnt_q;
`else
    logic unused_bubble;
    assign unused_bubble = bubble_d;
`endif

endmodule

// File: tb/tb_if_fetch_stage.sv
// Bench for if_fetch_stage: directed scenarios then random stall/redirect/ready traffic
// against a queue-based model of the fetch stream.
module tb_if_fetch_stage;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] NOP_WORD = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  dbg_state;
    logic [31:0] junk = 32'h0;

    if_fetch_stage_if bus();

    if_fetch_stage #(.RESET_PC(RESET_PC), .NOP_WORD(NOP_WORD)) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus.master),
        .dbg_state_o(dbg_state)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'hA5A5_0000;
    endfunction

    assign bus.imem_rdata = bus.imem_ready ? mem_word(bus.imem_addr) : junk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model: PC, boot flag, at most one held word, last delivered values.
    bit          m_valid = 1'b0;
    bit          m_boot;
    logic [31:0] m_pc;
    logic [31:0] m_held[$];
    logic [31:0] m_last_pc, m_last_ins;
    bit          m_en;
    logic [31:0] m_fetch, m_stall;
    logic [63:0] exp_q[$];

    task automatic deliver(input logic [31:0] p, input logic [31:0] ins);
        exp_q.push_back({p, ins});
        m_en = 1'b1;
    endtask

    task automatic step(input logic r, input logic s, input logic rd,
                        input logic [31:0] rpc, input logic rdy);
        logic [31:0] word;
        logic [63:0] e;
        @(negedge clk);
        rst             = r;
        bus.stall       = s;
        bus.redirect    = rd;
        bus.redirect_pc = rpc;
        bus.imem_ready  = rdy;
        junk            = $urandom;
        #1;
        if (m_valid) begin
            chk("imem_req", {31'h0, bus.imem_req}, {31'h0, (!m_boot && m_held.size() == 0)});
            if (!m_boot && m_held.size() == 0) chk("imem_addr", bus.imem_addr, m_pc);
        end
        @(posedge clk);
        word = mem_word(m_pc);
        m_en = 1'b0;
        if (r) begin
            m_valid = 1'b1;
            m_boot = 1'b1;
            m_pc = RESET_PC;
            m_held.delete();
            m_last_pc = 32'h0;
            m_last_ins = 32'h0;
            m_fetch = 32'h0;
            m_stall = 32'h0;
        end else if (m_valid) begin
            if (m_boot) begin
                m_boot = 1'b0;
                if (rd) m_pc = rpc & 32'hFFFF_FFFC;
            end else begin
                if (m_held.size() != 0 || !rdy) m_stall++;
                if (rd) begin
                    m_pc = rpc & 32'hFFFF_FFFC;
                    m_held.delete();
                    deliver(32'h0, NOP_WORD);
                end else if (m_held.size() != 0) begin
                    if (!s) begin
                        m_pc += 4;
                        deliver(m_pc, m_held.pop_front());
                        m_fetch++;
                    end
                end else if (rdy) begin
                    if (s) m_held.push_back(word);
                    else begin
                        m_pc += 4;
                        deliver(m_pc, word);
                        m_fetch++;
                    end
                end
            end
        end
        #1;
        if (m_valid) begin
            chk("en_reg", {31'h0, bus.en_reg}, {31'h0, m_en});
            if (m_en) begin
                e = exp_q.pop_front();
                m_last_pc = e[63:32];
                m_last_ins = e[31:0];
            end
            chk("pc_out", bus.pc_out, m_last_pc);
            chk("ins_out", bus.ins_out, m_last_ins);
`ifdef IF_PERF_CNT_EN
            chk("fetch_cnt", bus.fetch_cnt, m_fetch);
            chk("stall_cnt", bus.stall_cnt, m_stall);
`endif
        end
    endtask

    initial begin
        bus.stall = 1'b0;
        bus.redirect = 1'b0;
        bus.redirect_pc = 32'h0;
        bus.imem_ready = 1'b0;

        // Reset then free-running fetch
        step(1, 0, 0, 0, 1);
        step(1, 0, 0, 0, 1);
        step(0, 0, 0, 0, 1);
        repeat (2) step(0, 0, 0, 0, 1);
        // Memory wait at pc=8
        repeat (3) step(0, 0, 0, 0, 0);
        repeat (2) step(0, 0, 0, 0, 1);
        // Stall while word@16 returns, release with memory not ready
        repeat (2) step(0, 1, 0, 0, 1);
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 1);
        // Redirect beats stall and a ready word
        step(0, 1, 1, 32'h0000_0103, 1);
        repeat (2) step(0, 0, 0, 0, 1);
        // Redirect to the top word, PC wraps
        step(0, 0, 1, 32'hFFFF_FFFC, 1);
        repeat (2) step(0, 0, 0, 0, 1);
        // Reset while holding a word
        step(0, 1, 0, 0, 1);
        step(1, 0, 0, 0, 1);
        // Redirect during BOOT
        step(0, 0, 1, 32'h0000_0042, 1);
        repeat (3) step(0, 0, 0, 0, 1);
        // Redirect while holding drops the held word
        step(0, 1, 0, 0, 1);
        step(0, 1, 1, 32'h0000_0200, 0);
        repeat (2) step(0, 0, 0, 0, 1);

        for (int i = 0; i < 3000; i++) begin
            logic        r, s, rd, rdy;
            logic [31:0] rpc;
            r   = ($urandom_range(0, 199) == 0);
            s   = ($urandom_range(0, 3) == 0);
            rd  = ($urandom_range(0, 15) == 0);
            rdy = ($urandom_range(0, 3) != 0);
            rpc = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                               : $urandom;
            step(r, s, rd, rpc, rdy);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
